simd_issue_seq: RTL

//  Initiator/collector for the packed-integer SIMD ALU (simd_non_socialiste). Accepts 64b or 128b

---
 rtl/simd_issue_seq_pkg.sv | 15 +
 rtl/simd_issue_seq_rsp_fifo.sv | 39 +++
 rtl/simd_issue_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/simd_issue_seq_pkg.sv
// simd_issue_pkg: shared types and 64b<->68b register-format helpers for the SIMD issue sequencer
package simd_issue_pkg;
  localparam logic [1:0] PTYPE_INT = 2'd0;
  typedef enum logic {IDLE, HI} state_t;
  typedef struct packed {
    logic [127:0] data;
    logic         wide;
  } rsp_t;
  function automatic logic [67:0] pack64(input logic [63:0] v);
    return {PTYPE_INT, 1'b0, v[63:32], 1'b0, v[31:0]};
  endfunction
  function automatic logic [63:0] unpack68(input logic [67:0] r);
    return {r[64:33], r[31:0]};
  endfunction
endpackage

// File: rtl/simd_issue_seq_rsp_fifo.sv
// simd_rsp_fifo: first-word-fall-through response FIFO with occupancy count
module simd_rsp_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [AW:0]   count
);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic full, do_pop;
  assign valid = count != '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & valid;
  assign dout = mem[rp];
  always_ff @(negedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push ? wp + AW'(1) : wp;
      rp <= do_pop ? rp + AW'(1) : rp;
      count <= count + CW'(push) - CW'(do_pop);
    end
  always_ff @(negedge clk)
    if (push) mem[wp] <= din;
  // credits upstream must make this impossible; a violation is a design bug, never a drop
  always_ff @(negedge clk)
    if (!rst) assert (!(push && full && !do_pop));
endmodule

// File: rtl/simd_issue_seq.sv
// simd_issue_seq: issues 64b/128b SIMD ops to the fixed-latency ALU and returns in-order responses
module simd_issue_seq
  import simd_issue_pkg::*;
#(
  parameter int LAT = 2,
  parameter int DEPTH = 4,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [12:0]     req_op,
  input  logic            req_wide,
  input  logic [127:0]    req_a,
  input  logic [127:0]    req_b,
  input  logic [TAGW-1:0] req_tag,
  output logic            alu_en,
  output logic [12:0]     alu_op,
  output logic [67:0]     alu_a,
  output logic [67:0]     alu_b,
  input  logic [67:0]     alu_res,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [127:0]    rsp_data,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_wide
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = TAGW + $bits(rsp_t);
  typedef struct packed {
    logic            valid;
    logic            last;
    logic            wide;
    logic [TAGW-1:0] tag;
  } cap_t;
  state_t state, state_nx;
  logic [CW-1:0] cred, fcnt;
  logic issue_lo, issue_hi, push, pop;
  logic [63:0] hi_a, hi_b, lo_hold, res;
  logic last_r, wide_r;
  logic [TAGW-1:0] tag_r;
  cap_t pipe [LAT];
  cap_t cap;
  rsp_t ent, rsp;
  logic [FW-1:0] fout;
  logic unused_res_bits;
  assign unused_res_bits = ^{alu_res[67:65], alu_res[32]};
  always_ff @(negedge clk) state <= rst ? IDLE : state_nx;
  always_comb state_nx = (issue_lo && req_wide) ? HI : IDLE;
  always_comb begin
    req_ready = ~rst & (state == IDLE) & (cred != '0);
    issue_lo = req_valid & req_ready;
    issue_hi = state == HI;
  end
  // credits cover FIFO entries plus requests still in the ALU, so a push always finds room
  always_ff @(negedge clk) cred <= rst ? CW'(DEPTH) : cred - CW'(issue_lo) + CW'(pop);
  always_ff @(negedge clk)
    if (rst) begin
      alu_en <= 1'b0;
      alu_op <= '0;
      alu_a <= '0;
      alu_b <= '0;
      hi_a <= '0;
      hi_b <= '0;
      tag_r <= '0;
      wide_r <= 1'b0;
      last_r <= 1'b0;
    end else begin
      alu_en <= issue_lo | issue_hi;
      if (issue_lo) begin
        alu_op <= req_op;
        alu_a <= pack64(req_a[63:0]);
        alu_b <= pack64(req_b[63:0]);
        hi_a <= req_a[127:64];
        hi_b <= req_b[127:64];
        tag_r <= req_tag;
        wide_r <= req_wide;
        last_r <= ~req_wide;
      end else if (issue_hi) begin
        alu_a <= pack64(hi_a);
        alu_b <= pack64(hi_b);
        last_r <= 1'b1;
      end
    end
  // beat metadata travels alongside the ALU's enable pipe and meets alu_res at its output
  assign cap = pipe[LAT-1];
  assign res = unpack68(alu_res);
  assign push = cap.valid & cap.last;
  always_ff @(negedge clk) begin
    pipe[0] <= rst ? '0 : cap_t'{alu_en, last_r, wide_r, tag_r};
    for (int i = 1; i < LAT; i++) pipe[i] <= rst ? '0 : pipe[i-1];
    lo_hold <= rst ? '0 : (cap.valid & ~cap.last) ? res : lo_hold;
  end
  always_comb ent = '{data: cap.wide ? {res, lo_hold} : {64'b0, res}, wide: cap.wide};
  simd_rsp_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({cap.tag, ent}),
    .pop   (pop),
    .dout  (fout),
    .valid (rsp_valid),
    .count (fcnt)
  );
  assign pop = rsp_valid & rsp_ready;
  assign {rsp_tag, rsp} = fout;
  assign rsp_data = rsp.data;
  assign rsp_wide = rsp.wide;
  always_ff @(negedge clk)
    if (!rst) assert (fcnt + cred <= CW'(DEPTH));
endmodule
